// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus types, constants and timeout defaults
package bus_pkg;

  typedef enum logic [2:0] {
    BM_IDLE    = 3'd0,
    BM_REQ     = 3'd1,
    BM_XFER    = 3'd2,
    BM_SPLIT   = 3'd3,
    BM_RELEASE = 3'd4,
    BM_ABORT   = 3'd5
  } bm_state_t;

  localparam logic [3:0] MID_NONE = 4'hF;
  localparam logic [3:0] SID_NONE = 4'hF;

  localparam int unsigned REQ_TIMEOUT_DEF   = 1024;
  localparam int unsigned SPLIT_TIMEOUT_DEF = 4096;
  localparam int          CW_DEF            = 13;

endpackage

// File: rtl/bus_timeout_ctr.sv
// rtl/bus_timeout_ctr.sv - saturating timeout counter with programmable hit limit
module bus_timeout_ctr #(
  parameter int CW = 13
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          hit
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {CW{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt >= limit);

endmodule

// File: rtl/bus_master_ctrl.sv
// rtl/bus_master_ctrl.sv - per-master request/grant sequencer with split resume
module bus_master_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned REQ_TIMEOUT   = REQ_TIMEOUT_DEF,
  parameter int unsigned SPLIT_TIMEOUT = SPLIT_TIMEOUT_DEF,
  parameter int          CW            = CW_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       xfer_last,
  input  logic       m_grant,
  output logic       m_req,
  output logic       bus_util,
  output logic       xfer_en,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] split_cnt
);

  bm_state_t     state;
  logic          tmo_clr;
  logic          tmo_en;
  logic          tmo_hit;
  logic [CW-1:0] tmo_limit;

  // One counter serves both waits; it is cleared on entry to REQ and to SPLIT.
  assign tmo_clr   = ((state == BM_IDLE) && start) ||
                     ((state == BM_XFER) && !xfer_last && !m_grant);
  assign tmo_en    = (state == BM_REQ) || (state == BM_SPLIT);
  assign tmo_limit = (state == BM_SPLIT) ? CW'(SPLIT_TIMEOUT) : CW'(REQ_TIMEOUT);

  bus_timeout_ctr #(.CW(CW)) u_tmo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .limit (tmo_limit),
    .hit   (tmo_hit)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= BM_IDLE;
      m_req     <= 1'b0;
      bus_util  <= 1'b0;
      xfer_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      split_cnt <= 4'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        BM_IDLE: begin
          if (start) begin
            state     <= BM_REQ;
            m_req     <= 1'b1;
            busy      <= 1'b1;
            split_cnt <= 4'd0;
          end
        end
        BM_REQ: begin
          // A grant in the timeout cycle still wins.
          if (m_grant) begin
            state    <= BM_XFER;
            bus_util <= 1'b1;
            xfer_en  <= 1'b1;
          end else if (tmo_hit) begin
            state <= BM_ABORT;
            m_req <= 1'b0;
            err   <= 1'b1;
          end
        end
        BM_XFER: begin
          if (xfer_last) begin
            state    <= BM_RELEASE;
            m_req    <= 1'b0;
            bus_util <= 1'b0;
            xfer_en  <= 1'b0;
            done     <= 1'b1;
          end else if (!m_grant) begin
            state    <= BM_SPLIT;
            bus_util <= 1'b0;
            xfer_en  <= 1'b0;
            if (split_cnt != 4'd15) split_cnt <= split_cnt + 4'd1;
          end
        end
        BM_SPLIT: begin
          if (m_grant) begin
            state    <= BM_XFER;
            bus_util <= 1'b1;
            xfer_en  <= 1'b1;
          end else if (tmo_hit) begin
            state <= BM_ABORT;
            m_req <= 1'b0;
            err   <= 1'b1;
          end
        end
        BM_RELEASE, BM_ABORT: begin
          state <= BM_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= BM_IDLE;
          m_req    <= 1'b0;
          bus_util <= 1'b0;
          xfer_en  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// tb/tb_bus_master_ctrl.sv - directed self-checking bench for bus_master_ctrl
module tb_bus_master_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       xfer_last;
  logic       m_grant;
  logic       m_req;
  logic       bus_util;
  logic       xfer_en;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] split_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  bus_master_ctrl #(
    .REQ_TIMEOUT   (8),
    .SPLIT_TIMEOUT (16),
    .CW            (13)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .xfer_last (xfer_last),
    .m_grant   (m_grant),
    .m_req     (m_req),
    .bus_util  (bus_util),
    .xfer_en   (xfer_en),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .split_cnt (split_cnt)
  );

  task automatic check(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int t, input logic [6:0] exp);
    check({tag, "_mreq"}, t, 32'(m_req),    32'(exp[6]));
    check({tag, "_util"}, t, 32'(bus_util), 32'(exp[5]));
    check({tag, "_xen"},  t, 32'(xfer_en),  32'(exp[4]));
    check({tag, "_busy"}, t, 32'(busy),     32'(exp[3]));
    check({tag, "_done"}, t, 32'(done),     32'(exp[2]));
    check({tag, "_err"},  t, 32'(err),      32'(exp[1]));
  endtask

  initial begin
    int exp_sc;
    rstn = 1'b0; start = 1'b0; xfer_last = 1'b0; m_grant = 1'b0;
    tick(); tick();
    check_outs("rst", 0, 7'b0);
    check("rst_sc", 0, 32'(split_cnt), 32'd0);
    rstn = 1'b1;
    tick();

    // Basic transfer: grant at 3, last at 10.
    for (int t = 0; t <= 12; t++) begin
      start = (t == 0); m_grant = (t >= 3 && t <= 10); xfer_last = (t == 10);
      check_outs("basic", t, {(t >= 1 && t <= 10), (t >= 4 && t <= 10), (t >= 4 && t <= 10),
                              (t >= 1 && t <= 11), (t == 11), 1'b0, 1'b0});
      tick();
    end
    check("basic_sc", 13, 32'(split_cnt), 32'd0);

    // Single split: grant lost at 6, back at 20, last at 25.
    for (int t = 0; t <= 27; t++) begin
      start = (t == 0); xfer_last = (t == 25);
      m_grant = (t >= 3 && t <= 5) || (t >= 20 && t <= 25);
      check_outs("split", t, {(t >= 1 && t <= 25),
                              (t >= 4 && t <= 6) || (t >= 21 && t <= 25),
                              (t >= 4 && t <= 6) || (t >= 21 && t <= 25),
                              (t >= 1 && t <= 26), (t == 26), 1'b0, 1'b0});
      if (t == 26) check("split_sc", t, 32'(split_cnt), 32'd1);
      tick();
    end

    // Request timeout: REQ entered at 1, err 9 cycles later.
    for (int t = 0; t <= 12; t++) begin
      start = (t == 0); m_grant = 1'b0; xfer_last = 1'b0;
      check_outs("rtmo", t, {(t >= 1 && t <= 9), 1'b0, 1'b0, (t >= 1 && t <= 10), 1'b0, (t == 10), 1'b0});
      tick();
    end

    // Grant in the same cycle the request timeout hits: grant wins.
    for (int t = 0; t <= 12; t++) begin
      start = (t == 0); m_grant = (t >= 9); xfer_last = (t == 11);
      check_outs("gwin", t, {(t >= 1 && t <= 11), (t >= 10 && t <= 11), (t >= 10 && t <= 11),
                             (t >= 1 && t <= 12), (t == 12), 1'b0, 1'b0});
      tick();
    end
    m_grant = 1'b0; xfer_last = 1'b0;
    tick();

    // 17 splits saturate at 15; last coincident with grant loss releases without a split.
    for (int t = 0; t <= 40; t++) begin
      start = (t == 0);
      m_grant = (t >= 3 && t <= 37 && (t % 2 == 1));
      xfer_last = (t == 38);
      exp_sc = (t < 5) ? 0 : (((t < 37 ? t : 37) - 3) / 2);
      if (exp_sc > 15) exp_sc = 15;
      check("sat_sc", t, 32'(split_cnt), 32'(exp_sc));
      check("sat_util", t, 32'(bus_util), 32'(t >= 4 && t <= 38 && (t % 2 == 0)));
      check("sat_done", t, 32'(done), 32'(t == 39));
      tick();
    end

    // Asynchronous reset mid-XFER.
    for (int t = 0; t <= 6; t++) begin
      start = (t == 0); m_grant = (t >= 3); xfer_last = 1'b0;
      if (t < 6) tick();
    end
    check("pre_rst_util", 6, 32'(bus_util), 32'd1);
    rstn = 1'b0;
    #1;
    check_outs("arst", 6, 7'b0);
    #1;
    rstn = 1'b1;
    tick();
    check_outs("arst_idle", 7, 7'b0);
    m_grant = 1'b0;
    tick();

    // Start while busy is ignored and does not clear the split timer (entry 7, err at 24).
    for (int t = 0; t <= 26; t++) begin
      start = (t == 0) || (t == 4) || (t == 9) || (t == 15);
      m_grant = (t >= 3 && t <= 5); xfer_last = 1'b0;
      check_outs("ign", t, {(t >= 1 && t <= 23), (t >= 4 && t <= 6), (t >= 4 && t <= 6),
                            (t >= 1 && t <= 24), 1'b0, (t == 24), 1'b0});
      if (t >= 8 && t <= 24) check("ign_sc", t, 32'(split_cnt), 32'd1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
